bpsk_receiver: RTL
==================

// Module: bpsk_receiver
// PURPOSE
//  Coherent BPSK demodulator: receive end of the sine/phase-shift transmitter chain. Correlates signed
//  carrier samples against the shared sine table over one carrier wavelength per bit, slices the sign
//  into a bit, and assembles PACKET_SIZE bits into a packet word. Sample stream is symbol-aligned:
//  the first sample after reset is phase index 0 of bit 0.
// PARAMETERS
//  DATA_WIDTH        8    sample and sine-table width, signed two's complement
//  WAVELENGTH        16   samples per carrier period = samples per bit
//  PACKET_SIZE       128  bits per packet
//  ERASURE_THRESHOLD 256  |correlation| below this flags an erasure (BPSK_RX_ERASURE_EN only)
// PORTS
//  clock          in   1                 system clock, rising edge
//  reset          in   1                 asynchronous, active-high
//  sample_valid   in   1                 sample is accepted on this edge
//  sample         in   DATA_WIDTH        signed received amplitude
//  bit_valid      out  1                 one-cycle pulse, bit_data valid
//  bit_data       out  1                 sliced bit
//  packet_valid   out  1                 one-cycle pulse, packet_data updated
//  packet_data    out  PACKET_SIZE       packet; [PACKET_SIZE-1] = first bit received
//  packet_erasure out  1                 BPSK_RX_ERASURE_EN only; qualifies packet_data
// BEHAVIOUR
//  - Reset: all outputs 0, phase_idx=0, bit_idx=0, accumulator=0, state=ACCUM.
//  - ref[k] = round((2^(DATA_WIDTH-1)-1)*sin(2*pi*k/WAVELENGTH)); DATA_WIDTH=8,WAVELENGTH=16: ref[4]=127.
//  - Mapping: bit 0 = in-phase carrier, bit 1 = 180-degree shifted (inverted) carrier.
//  - States: ACCUM, DECIDE. ACCUM: on sample_valid, acc += sample*ref[phase_idx]; phase_idx++.
//    Accepting phase_idx=WAVELENGTH-1 wraps phase_idx to 0 and moves to DECIDE.
//  - DECIDE (exactly one cycle): bit = (acc<0); bit_valid=1; shift bit into packet shift register;
//    acc cleared; -> ACCUM. Any sample_valid during DECIDE is accepted as phase 0 of next bit
//    (acc loads sample*ref[0]); no sample is ever dropped.
//  - Latency: bit_valid pulses the cycle after the edge accepting the last sample of the bit.
//  - acc==0 slices to 0. Widths: product 2*DATA_WIDTH signed; acc 2*DATA_WIDTH+$clog2(WAVELENGTH)
//    signed, no saturation required (cannot overflow).
//  - bit_idx counts 0..PACKET_SIZE-1; on bit PACKET_SIZE-1 packet_data loads the full shift
//    register (incl. that bit) in same cycle as bit_valid; packet_valid pulses; bit_idx wraps to 0.
//    packet_data holds until the next packet completes.
//  - sample_valid low: counters and acc hold; gaps of any length allowed.
//  - Reset mid-bit or mid-packet: partial bit and partial packet discarded; realignment to phase 0.
// CONFIGURATION
//  BPSK_RX_ERASURE_EN defined: in DECIDE, |acc| < ERASURE_THRESHOLD sets a sticky per-packet flag;
//  packet_erasure loads the flag with packet_data; flag clears at packet start. Not defined:
//  packet_erasure port, threshold compare and flag are absent; all else identical.
// STRUCTURE
//  - Shared package bpsk_pkg: DATA_WIDTH, WAVELENGTH, PACKET_SIZE, sine-table function/constant
//    (same table the transmitter sine generator uses), state enum {ACCUM, DECIDE}.
//  - Sub-module bpsk_correlator: sine lookup, multiply, accumulate, clear; top holds FSM,
//    bit/packet counters, shift register, erasure logic.
// TESTING
//  1 Clean in-phase carrier ref[k], 16 samples, continuous valid -> bit_valid on cycle 17, bit_data=0.
//  2 Inverted carrier -ref[k] -> bit_data=1; alternate 0/1 symbols for 8 bits -> 0,1,0,1,0,1,0,1.
//  3 128-bit packet ASCII "Hello world" (0x48656C6C6F20776F726C64) zero-padded, MSB first ->
//    one packet_valid after 2048 samples, packet_data == 0x48656C6C6F20776F726C64 << 40.
//  4 Same stream with random sample_valid gaps (1-5 cycles) and valid in DECIDE -> identical packet_data.
//  5 reset pulse after 7 samples of bit 3 -> no bit_valid; next 128*16 samples give a correct packet.
//  6 (ERASURE_EN) one bit of packet sent as all-zero samples -> that bit 0, packet_erasure=1;
//    next clean packet -> packet_erasure=0.

Source files
------------

// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions: sizes, state enum and the sine table also used by the transmitter.
// The table is tabulated for DATA_WIDTH=8, WAVELENGTH=16.
package bpsk_pkg;
  localparam int DATA_WIDTH        = 8;
  localparam int WAVELENGTH        = 16;
  localparam int PACKET_SIZE       = 128;
  localparam int ERASURE_THRESHOLD = 256;

  localparam int PHASE_W   = $clog2(WAVELENGTH);
  localparam int BIT_IDX_W = $clog2(PACKET_SIZE);
  localparam int PROD_W    = 2 * DATA_WIDTH;
  localparam int ACC_W     = PROD_W + PHASE_W;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef logic signed [PROD_W-1:0]     prod_t;
  typedef logic signed [ACC_W-1:0]      acc_t;

  typedef enum logic {ACCUM, DECIDE} rx_state_e;

  // round(127*sin(2*pi*k/16))
  localparam sample_t SINE_TAB [WAVELENGTH] = '{
    8'sd0,  8'sd49,  8'sd90,  8'sd117,  8'sd127,  8'sd117,  8'sd90,  8'sd49,
    8'sd0, -8'sd49, -8'sd90, -8'sd117, -8'sd127, -8'sd117, -8'sd90, -8'sd49
  };

  function automatic sample_t sine_ref(input logic [PHASE_W-1:0] k);
    return SINE_TAB[k];
  endfunction
endpackage

// File: rtl/bpsk_receiver_if.sv
// Sample input / bit and packet output bundle of the BPSK receiver.
// packet_erasure exists only when BPSK_RX_ERASURE_EN is defined.
interface bpsk_receiver_if;
  import bpsk_pkg::*;

  logic                   sample_valid;
  sample_t                sample;
  logic                   bit_valid;
  logic                   bit_data;
  logic                   packet_valid;
  logic [PACKET_SIZE-1:0] packet_data;
`ifdef BPSK_RX_ERASURE_EN
  logic                   packet_erasure;

  modport master (output sample_valid, sample,
                  input  bit_valid, bit_data, packet_valid, packet_data, packet_erasure);
  modport slave  (input  sample_valid, sample,
                  output bit_valid, bit_data, packet_valid, packet_data, packet_erasure);
`else
  modport master (output sample_valid, sample,
                  input  bit_valid, bit_data, packet_valid, packet_data);
  modport slave  (input  sample_valid, sample,
                  output bit_valid, bit_data, packet_valid, packet_data);
`endif
endinterface

// File: rtl/bpsk_correlator.sv
// Multiplies each sample by the reference sine at its phase and accumulates over one bit.
// clear restarts the sum; a sample accepted on the same edge seeds the new sum.
module bpsk_correlator
  import bpsk_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               accept,
  input  logic               clear,
  input  logic [PHASE_W-1:0] phase,
  input  sample_t            sample,
  output acc_t               acc
);
  prod_t prod;
  assign prod = sample * sine_ref(phase);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       acc <= '0;
    else if (clear)  acc <= accept ? ACC_W'(prod) : '0;
    else if (accept) acc <= acc + ACC_W'(prod);
  end
endmodule

// File: rtl/bpsk_receiver.sv
// Coherent BPSK demodulator: correlate one carrier period per bit, slice, pack into packets.
// Optional erasure flagging is enabled by defining BPSK_RX_ERASURE_EN.
module bpsk_receiver
  import bpsk_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  bpsk_receiver_if.slave rx
);
  rx_state_e              state, state_next;
  logic [PHASE_W-1:0]     phase_idx;
  logic [BIT_IDX_W-1:0]   bit_idx;
  logic [PACKET_SIZE-2:0] shreg;
  logic [PACKET_SIZE-1:0] shreg_next, packet_q;
  acc_t                   acc;
  logic                   decide, last_phase, last_bit, bit_now;

  assign decide     = (state == DECIDE);
  assign last_phase = (phase_idx == PHASE_W'(WAVELENGTH - 1));
  assign last_bit   = (bit_idx == BIT_IDX_W'(PACKET_SIZE - 1));
  assign bit_now    = acc[ACC_W-1];
  assign shreg_next = {shreg, bit_now};

  bpsk_correlator u_corr (
    .clock  (clock),
    .reset  (reset),
    .accept (rx.sample_valid),
    .clear  (decide),
    .phase  (phase_idx),
    .sample (rx.sample),
    .acc    (acc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ACCUM;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:  if (rx.sample_valid && last_phase) state_next = DECIDE;
      DECIDE: state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Phase keeps counting through DECIDE so a back-to-back sample is never lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 phase_idx <= '0;
    else if (rx.sample_valid)  phase_idx <= last_phase ? '0 : phase_idx + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_idx  <= '0;
      shreg    <= '0;
      packet_q <= '0;
    end else if (decide) begin
      shreg   <= shreg_next[PACKET_SIZE-2:0];
      bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
      if (last_bit) packet_q <= shreg_next;
    end
  end

  // Completed packet is presented in the DECIDE cycle itself, then held.
  assign rx.bit_valid    = decide;
  assign rx.bit_data     = decide & bit_now;
  assign rx.packet_valid = decide & last_bit;
  assign rx.packet_data  = rx.packet_valid ? shreg_next : packet_q;

`ifdef BPSK_RX_ERASURE_EN
  localparam acc_t ERASE_LIM = acc_t'(ERASURE_THRESHOLD);
  logic weak, flag, flag_next, erasure_q;

  assign weak      = (acc < ERASE_LIM) && (acc > -ERASE_LIM);
  assign flag_next = ((bit_idx == '0) ? 1'b0 : flag) | weak;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag      <= 1'b0;
      erasure_q <= 1'b0;
    end else if (decide) begin
      flag <= flag_next;
      if (last_bit) erasure_q <= flag_next;
    end
  end

  assign rx.packet_erasure = rx.packet_valid ? flag_next : erasure_q;
`endif
endmodule
